// File: rtl/inst_rom_pipe.sv
// Instruction ROM with a program-load port and a one-stage registered fetch
// output feeding the IF/ID register. Two modes: RUN serves fetches, LOAD
// streams words into the array from a wrapping write pointer.
module inst_rom_pipe #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 64,
  parameter int unsigned       ADDR_W   = 6,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mode,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_done,
  output logic              ld_wrap,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              flush,
  input  logic              stall,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_err
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  // One extra bit so DEPTH itself (e.g. 64 with 6-bit addresses) is representable.
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              accept;
  logic              addr_ok;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign fetch_ready = (state_q == ST_RUN) & ~load_mode & ~stall & ~flush;
  assign accept      = fetch_valid & fetch_ready;
  assign addr_ok     = {1'b0, fetch_addr} < DEPTH_C;

  // Mode FSM, load pointer, wrap flag and the done pulse request.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    wrap_d  = wrap_q;
    mem_we  = 1'b0;
    done_d  = (state_q == ST_LOAD) && !load_mode;
    case (state_q)
      ST_RUN: begin
        if (load_mode) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          wrap_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          mem_we = 1'b1;
          if (ptr_q == PTR_LAST) begin
            ptr_d  = '0;
            wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
        if (!load_mode) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Next fetch output: flush/load kill it, stall holds it, accept loads it.
  always_comb begin
    inst_d  = inst_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (flush || load_mode || (state_q == ST_LOAD)) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (stall) begin
      inst_d  = inst_q;
    end else if (accept) begin
      valid_d = 1'b1;
      if (addr_ok) begin
        inst_d = mem_q[fetch_addr];
        err_d  = 1'b0;
      end else begin
        inst_d = NOP_INST;
        err_d  = 1'b1;
      end
    end else begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Program array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps onto RAM and a reset in the
    // middle of a load keeps the words already written.
    if (mem_we) mem_q[ptr_q] <= ld_data;
  end

  assign ld_done    = done_q;
  assign ld_wrap    = wrap_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign addr_err   = err_q;

endmodule

// File: tb/tb_inst_rom_pipe.sv
// Scoreboard bench for inst_rom_pipe: a behavioural model predicts each
// cycle's registered outputs when stimulus is driven; the prediction is
// queued and compared once the DUT has clocked. A second DEPTH=48 instance
// shares the inputs and covers out-of-range addresses.
module tb_inst_rom_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        load_mode;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        fetch_valid;
  logic [5:0]  fetch_addr;
  logic        flush;
  logic        stall;

  logic        ld_done, ld_wrap, fetch_ready, inst_valid, addr_err;
  logic [31:0] inst;
  logic        ld_done48, ld_wrap48, fetch_ready48, inst_valid48, addr_err48;
  logic [31:0] inst48;

  inst_rom_pipe u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_mode   (load_mode),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_done     (ld_done),
    .ld_wrap     (ld_wrap),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .stall       (stall),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .addr_err    (addr_err)
  );

  inst_rom_pipe #(.DEPTH(48), .ADDR_W(6)) u_dut48 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_mode   (load_mode),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_done     (ld_done48),
    .ld_wrap     (ld_wrap48),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready48),
    .flush       (flush),
    .stall       (stall),
    .inst        (inst48),
    .inst_valid  (inst_valid48),
    .addr_err    (addr_err48)
  );

  typedef struct {
    logic [31:0] inst;
    logic        iv;
    logic        err;
    logic        done;
    logic        wrap;
    bit          known;
    bit          chk48;
    logic        err48;
  } exp_t;

  exp_t sb_q[$];

  int checks;
  int failures;

  // Reference model state (DEPTH=64 instance).
  logic [31:0] ref_mem [64];
  bit          ref_def [64];
  bit          m_load;
  int          m_ptr;
  logic        m_wrap;
  logic [31:0] m_inst;
  logic        m_iv;
  logic        m_err;
  bit          m_known;
  bit          en48;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; called at the falling edge, returns at the next one.
  task automatic cycle(input logic lm, input logic lv, input logic [31:0] ld,
                       input logic fv, input logic [5:0] fa,
                       input logic st, input logic fl);
    exp_t e;
    logic ready_exp;
    logic acc;
    load_mode   = lm;
    ld_valid    = lv;
    ld_data     = ld;
    fetch_valid = fv;
    fetch_addr  = fa;
    stall       = st;
    flush       = fl;
    #1;
    ready_exp = !m_load && !lm && !st && !fl;
    check("fetch_ready", {31'b0, fetch_ready}, {31'b0, ready_exp});
    acc = fv && ready_exp;

    if (fl || lm || m_load) begin
      e.inst = NOP; e.iv = 1'b0; e.err = 1'b0; e.known = 1'b1;
    end else if (st) begin
      e.inst = m_inst; e.iv = m_iv; e.err = m_err; e.known = m_known;
    end else if (acc) begin
      e.inst = ref_mem[fa]; e.iv = 1'b1; e.err = 1'b0; e.known = ref_def[fa];
    end else begin
      e.inst = NOP; e.iv = 1'b0; e.err = 1'b0; e.known = 1'b1;
    end
    e.done  = m_load && !lm;
    e.chk48 = en48 && acc;
    e.err48 = (fa >= 6'd48);

    if (!m_load && lm) begin
      m_ptr  = 0;
      m_wrap = 1'b0;
    end else if (m_load && lv) begin
      ref_mem[m_ptr] = ld;
      ref_def[m_ptr] = 1'b1;
      if (m_ptr == 63) begin
        m_ptr  = 0;
        m_wrap = 1'b1;
      end else begin
        m_ptr++;
      end
    end
    e.wrap  = m_wrap;
    m_load  = lm;
    m_inst  = e.inst;
    m_iv    = e.iv;
    m_err   = e.err;
    m_known = e.known;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("inst_valid", {31'b0, inst_valid}, {31'b0, e.iv});
    check("addr_err", {31'b0, addr_err}, {31'b0, e.err});
    check("ld_done", {31'b0, ld_done}, {31'b0, e.done});
    check("ld_wrap", {31'b0, ld_wrap}, {31'b0, e.wrap});
    if (e.known) check("inst", inst, e.inst);
    if (e.chk48) begin
      check("inst_valid48", {31'b0, inst_valid48}, 32'd1);
      check("addr_err48", {31'b0, addr_err48}, {31'b0, e.err48});
      if (e.err48) check("inst48", inst48, NOP);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input logic [5:0] a);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic load_word(input logic [31:0] d);
    cycle(1'b1, 1'b1, d, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic reset_pulse();
    load_mode   = 1'b0;
    ld_valid    = 1'b0;
    fetch_valid = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("rst_inst", inst, NOP);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_addr_err", {31'b0, addr_err}, 32'd0);
    check("rst_ld_done", {31'b0, ld_done}, 32'd0);
    check("rst_ld_wrap", {31'b0, ld_wrap}, 32'd0);
    check("rst_inst48", inst48, NOP);
    m_load = 1'b0; m_ptr = 0; m_wrap = 1'b0;
    m_inst = NOP; m_iv = 1'b0; m_err = 1'b0; m_known = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    en48 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'h0;
      ref_def[i] = 1'b0;
    end
    rst_n = 1'b1;
    #2;
    reset_pulse();

    // First accept on the first edge after reset release (unwritten word).
    fetch(6'd5);
    idle();

    // Four-word program load with a bubble; fetches during LOAD stay dead.
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 6'd0, 1'b0, 1'b0);
    load_word(32'h11);
    load_word(32'h22);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 6'd3, 1'b0, 1'b0);
    load_word(32'h33);
    load_word(32'h44);
    idle();
    idle();

    fetch(6'd2);
    fetch(6'd0);
    fetch(6'd1);
    fetch(6'd3);

    // Range boundary on the 48-deep instance.
    fetch(6'd50);
    fetch(6'd47);
    fetch(6'd48);
    fetch(6'd63);

    // Writes outside LOAD are ignored.
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 6'd0, 1'b0, 1'b0);
    fetch(6'd0);

    // Stall holds the output for three cycles.
    fetch(6'd1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1, 6'd3, 1'b1, 1'b0);
    // Flush beats stall, then flush on its own.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 6'd3, 1'b1, 1'b1);
    fetch(6'd2);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 6'd2, 1'b0, 1'b1);
    fetch(6'd3);
    idle();

    // Entering LOAD under stall still kills the output; then 65-word wrap load.
    fetch(6'd2);
    en48 = 1'b0;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 65; i++) load_word(32'h1000 + i);
    idle();
    idle();
    fetch(6'd0);
    fetch(6'd1);
    fetch(6'd63);

    // Reset while output valid and ld_wrap set.
    reset_pulse();
    idle();

    // Reset mid-load after two words: load aborted, words retained.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    load_word(32'hA1);
    load_word(32'hA2);
    reset_pulse();
    idle();
    idle();
    fetch(6'd0);
    fetch(6'd1);
    fetch(6'd2);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_rom_pipe.md
INST_ROM_PIPE -- requirements
Module: inst_rom_pipe

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 64, number of instruction words stored.
REQ-003 Parameter ADDR_W, default 6, fetch address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 Parameter NOP_INST, default 32'h00000013, word driven whenever no valid instruction is presented.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 load_mode  input  1  request program-load mode.
REQ-008 ld_valid  input  1  ld_data valid this cycle.
REQ-009 ld_data  input  DATA_W  word to store at load pointer.
REQ-010 ld_done  output  1  one-cycle pulse on leaving load mode.
REQ-011 ld_wrap  output  1  sticky; set when load pointer wrapped in current load session.
REQ-012 fetch_valid  input  1  fetch request valid.
REQ-013 fetch_addr  input  ADDR_W  word address of fetch.
REQ-014 fetch_ready  output  1  fetch can be accepted this cycle.
REQ-015 flush  input  1  kill pending/next output (from hazard detect unit).
REQ-016 stall  input  1  hold output register.
REQ-017 inst  output  DATA_W  registered instruction to IF_ID.
REQ-018 inst_valid  output  1  inst holds a fetched word.
REQ-019 addr_err  output  1  registered; fetched address >= DEPTH.

Function
REQ-020 State machine SHALL have states RUN and LOAD; reset state RUN.
REQ-021 RUN -> LOAD when load_mode=1; LOAD -> RUN when load_mode=0, with ld_done=1 for exactly that transition cycle +1 (registered pulse, one cycle).
REQ-022 On RUN->LOAD, load pointer SHALL clear to 0 and ld_wrap SHALL clear.
REQ-023 In LOAD, ld_valid=1 SHALL write ld_data to mem[ptr] and increment ptr; ptr at DEPTH-1 wraps to 0 and sets ld_wrap.
REQ-024 ld_valid in RUN SHALL be ignored; no memory write.
REQ-025 fetch_ready = (state==RUN) & ~load_mode & ~stall & ~flush, combinational.
REQ-026 Accept = fetch_valid & fetch_ready; read latency exactly one cycle.
REQ-027 Cycle after accept with fetch_addr < DEPTH: inst=mem[fetch_addr], inst_valid=1, addr_err=0.
REQ-028 Cycle after accept with fetch_addr >= DEPTH: inst=NOP_INST, inst_valid=1, addr_err=1.
REQ-029 Cycle with no accept, no stall, no flush: next inst=NOP_INST, inst_valid=0, addr_err=0.
REQ-030 stall=1 (no flush): inst, inst_valid, addr_err SHALL hold.
REQ-031 flush=1: highest priority; next cycle inst=NOP_INST, inst_valid=0, addr_err=0, overriding stall.
REQ-032 flush and stall simultaneous: flush wins per REQ-031.
REQ-033 Entering LOAD SHALL drive next inst=NOP_INST, inst_valid=0; output stays invalid throughout LOAD.
REQ-034 Memory contents SHALL not be reset; read of never-written location returns whatever is stored (bench must not rely on value).

Reset
REQ-035 rst_n=0 SHALL immediately force: state RUN, ptr 0, ld_wrap 0, ld_done 0, inst NOP_INST, inst_valid 0, addr_err 0.
REQ-036 Reset during LOAD SHALL abort load (no ld_done pulse); already-written words retained.
REQ-037 First accept possible on first rising edge after rst_n deasserts, provided load_mode=0.

Verification
REQ-038 Load 4 words 0x11,0x22,0x33,0x44 via ld_valid in LOAD, drop load_mode -> ld_done pulses 1 cycle; fetch addr 2 -> next cycle inst=0x33, inst_valid=1.
REQ-039 DEPTH=48, ADDR_W=6, fetch addr 50 -> next cycle inst=0x00000013, inst_valid=1, addr_err=1.
REQ-040 Fetch addr 1 (inst=0x22), stall=1 for 3 cycles with fetch_valid=1 -> fetch_ready=0, inst stays 0x22, inst_valid 1.
REQ-041 flush=1 with stall=1 and fetch_valid=1 -> fetch_ready=0; next cycle inst=0x00000013, inst_valid=0.
REQ-042 DEPTH=64 load of 65 words -> ld_wrap=1, mem[0] holds word 65.
REQ-043 rst_n pulsed low mid-load after 2 words -> outputs reset immediately, no ld_done, state RUN, mem[0..1] retained on subsequent fetch.
